// File: rtl/exm.sv
// Execute stage: ALU op and branch resolution feeding a 1-deep valid/ready result slot.
// Define ECAP5_DPROC_SERIAL_SHIFT_EN to replace the barrel shifter with a bit-serial shifter.
module exm #(
  parameter int unsigned BR_OFF_W = 20
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                input_valid_i,
  output logic                input_ready_o,
  input  logic [31:0]         pc_i,
  input  logic [31:0]         op1_i,
  input  logic [31:0]         op2_i,
  input  logic [2:0]          alu_op_i,
  input  logic                alu_sub_i,
  input  logic                shift_left_i,
  input  logic                shift_arith_i,
  input  logic [2:0]          br_cond_i,
  input  logic [BR_OFF_W-1:0] br_off_i,
  input  logic                ls_enable_i,
  input  logic                ls_write_i,
  input  logic                ls_unsigned_i,
  input  logic [3:0]          ls_sel_i,
  input  logic [31:0]         ls_wdata_i,
  input  logic                reg_write_i,
  input  logic [4:0]          reg_addr_i,
  output logic                output_valid_o,
  input  logic                output_ready_i,
  output logic [31:0]         alu_result_o,
  output logic                ls_enable_o,
  output logic                ls_write_o,
  output logic                ls_unsigned_o,
  output logic [3:0]          ls_sel_o,
  output logic [31:0]         ls_wdata_o,
  output logic                reg_write_o,
  output logic [4:0]          reg_addr_o,
  output logic                branch_o,
  output logic [31:0]         branch_target_o
);

  localparam logic [2:0] OpAdd   = 3'd0;
  localparam logic [2:0] OpXor   = 3'd1;
  localparam logic [2:0] OpOr    = 3'd2;
  localparam logic [2:0] OpAnd   = 3'd3;
  localparam logic [2:0] OpSlt   = 3'd4;
  localparam logic [2:0] OpSltu  = 3'd5;
  localparam logic [2:0] OpShift = 3'd6;

  typedef struct packed {
    logic [31:0] res;
    logic        ls_enable;
    logic        ls_write;
    logic        ls_unsigned;
    logic [3:0]  ls_sel;
    logic [31:0] ls_wdata;
    logic        reg_write;
    logic [4:0]  reg_addr;
  } slot_t;

  logic        valid_q;
  slot_t       slot_q;
  logic        branch_q;
  logic [31:0] target_q;

  logic        accept;
  logic        slot_free;
  logic        taken;
  logic [31:0] target;
  logic [31:0] alu_res;
  logic [4:0]  shamt;
  slot_t       in_slot;

  logic        load_en;
  slot_t       load_slot;
  logic        load_br;
  logic [31:0] load_tgt;

  assign shamt     = op2_i[4:0];
  assign slot_free = !valid_q || output_ready_i;
  assign accept    = input_valid_i && input_ready_o;
  assign target    = pc_i + {{(32 - BR_OFF_W){br_off_i[BR_OFF_W-1]}}, br_off_i};

`ifdef ECAP5_DPROC_SERIAL_SHIFT_EN
  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e      state_q;
  logic [31:0] sh_q;
  logic [4:0]  cnt_q;
  logic        left_q;
  logic        arith_q;
  slot_t       pend_q;
  logic        pend_br_q;
  logic [31:0] pend_tgt_q;
  logic        long_shift;

  function automatic logic [31:0] shift1(logic [31:0] v, logic left, logic arith);
    return left ? {v[30:0], 1'b0} : {arith & v[31], v[31:1]};
  endfunction

  assign input_ready_o = slot_free && (state_q == StIdle);
  // Amounts 0 and 1 finish in the accept cycle; longer ones park in StShift.
  assign long_shift    = (alu_op_i == OpShift) && (shamt > 5'd1);
`else
  assign input_ready_o = slot_free;
`endif

  always_comb begin
    unique case (br_cond_i)
      3'd1:    taken = (op1_i == op2_i);
      3'd2:    taken = (op1_i != op2_i);
      3'd3:    taken = ($signed(op1_i) < $signed(op2_i));
      3'd4:    taken = ($signed(op1_i) >= $signed(op2_i));
      3'd5:    taken = (op1_i < op2_i);
      3'd6:    taken = (op1_i >= op2_i);
      3'd7:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    unique case (alu_op_i)
      OpAdd:   alu_res = alu_sub_i ? (op1_i - op2_i) : (op1_i + op2_i);
      OpXor:   alu_res = op1_i ^ op2_i;
      OpOr:    alu_res = op1_i | op2_i;
      OpAnd:   alu_res = op1_i & op2_i;
      OpSlt:   alu_res = {31'b0, $signed(op1_i) < $signed(op2_i)};
      OpSltu:  alu_res = {31'b0, op1_i < op2_i};
`ifdef ECAP5_DPROC_SERIAL_SHIFT_EN
      OpShift: alu_res = (shamt == 5'd0) ? op1_i : shift1(op1_i, shift_left_i, shift_arith_i);
`else
      OpShift: begin
        if (shift_left_i)       alu_res = op1_i << shamt;
        else if (shift_arith_i) alu_res = 32'($signed(op1_i) >>> shamt);
        else                    alu_res = op1_i >> shamt;
      end
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    in_slot             = '0;
    in_slot.res         = alu_res;
    in_slot.ls_enable   = ls_enable_i;
    in_slot.ls_write    = ls_write_i;
    in_slot.ls_unsigned = ls_unsigned_i;
    in_slot.ls_sel      = ls_sel_i;
    in_slot.ls_wdata    = ls_wdata_i;
    in_slot.reg_write   = reg_write_i;
    in_slot.reg_addr    = reg_addr_i;
  end

  always_comb begin
    load_en   = 1'b0;
    load_slot = in_slot;
    load_br   = taken;
    load_tgt  = target;
`ifdef ECAP5_DPROC_SERIAL_SHIFT_EN
    if (state_q == StIdle) begin
      load_en = accept && !long_shift;
    end else if (cnt_q == 5'd1 && slot_free) begin
      load_en       = 1'b1;
      load_slot     = pend_q;
      load_slot.res = shift1(sh_q, left_q, arith_q);
      load_br       = pend_br_q;
      load_tgt      = pend_tgt_q;
    end
`else
    load_en = accept;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      slot_q     <= '0;
      branch_q   <= 1'b0;
      target_q   <= '0;
`ifdef ECAP5_DPROC_SERIAL_SHIFT_EN
      state_q    <= StIdle;
      sh_q       <= '0;
      cnt_q      <= '0;
      left_q     <= 1'b0;
      arith_q    <= 1'b0;
      pend_q     <= '0;
      pend_br_q  <= 1'b0;
      pend_tgt_q <= '0;
`endif
    end else begin
      branch_q <= 1'b0;
      if (output_ready_i) begin
        valid_q          <= 1'b0;
        slot_q.reg_write <= 1'b0;
      end
      if (load_en) begin
        valid_q <= 1'b1;
        slot_q  <= load_slot;
        if (load_br) begin
          branch_q <= 1'b1;
          target_q <= load_tgt;
        end
      end
`ifdef ECAP5_DPROC_SERIAL_SHIFT_EN
      case (state_q)
        StIdle: begin
          if (accept && long_shift) begin
            state_q    <= StShift;
            sh_q       <= alu_res;
            cnt_q      <= 5'(shamt - 5'd1);
            left_q     <= shift_left_i;
            arith_q    <= shift_arith_i;
            pend_q     <= in_slot;
            pend_br_q  <= taken;
            pend_tgt_q <= target;
          end
        end
        StShift: begin
          if (cnt_q > 5'd1) begin
            sh_q  <= shift1(sh_q, left_q, arith_q);
            cnt_q <= cnt_q - 5'd1;
          end else if (slot_free) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
`endif
    end
  end

  assign output_valid_o  = valid_q;
  assign alu_result_o    = slot_q.res;
  assign ls_enable_o     = slot_q.ls_enable;
  assign ls_write_o      = slot_q.ls_write;
  assign ls_unsigned_o   = slot_q.ls_unsigned;
  assign ls_sel_o        = slot_q.ls_sel;
  assign ls_wdata_o      = slot_q.ls_wdata;
  assign reg_write_o     = slot_q.reg_write;
  assign reg_addr_o      = slot_q.reg_addr;
  assign branch_o        = branch_q;
  assign branch_target_o = target_q;

endmodule

// File: tb/tb_exm.sv
// Scoreboard bench for exm: expected slot contents are queued on accept and checked on drain.
module tb_exm;

  localparam int unsigned BW = 20;
`ifdef ECAP5_DPROC_SERIAL_SHIFT_EN
  localparam int SHIFT31_LAT = 31;
`else
  localparam int SHIFT31_LAT = 1;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          input_valid_i;
  logic          input_ready_o;
  logic [31:0]   pc_i, op1_i, op2_i;
  logic [2:0]    alu_op_i;
  logic          alu_sub_i, shift_left_i, shift_arith_i;
  logic [2:0]    br_cond_i;
  logic [BW-1:0] br_off_i;
  logic          ls_enable_i, ls_write_i, ls_unsigned_i;
  logic [3:0]    ls_sel_i;
  logic [31:0]   ls_wdata_i;
  logic          reg_write_i;
  logic [4:0]    reg_addr_i;
  logic          output_valid_o;
  logic          output_ready_i;
  logic [31:0]   alu_result_o;
  logic          ls_enable_o, ls_write_o, ls_unsigned_o;
  logic [3:0]    ls_sel_o;
  logic [31:0]   ls_wdata_o;
  logic          reg_write_o;
  logic [4:0]    reg_addr_o;
  logic          branch_o;
  logic [31:0]   branch_target_o;

  typedef struct packed {
    logic [31:0] res;
    logic        ls_en;
    logic        ls_wr;
    logic        ls_un;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        rw;
    logic [4:0]  ra;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        exp_br = 1'b0;
  logic [31:0] exp_tgt = '0;
  logic        acc_flag;

  exm #(.BR_OFF_W(BW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .input_valid_i(input_valid_i), .input_ready_o(input_ready_o),
    .pc_i(pc_i), .op1_i(op1_i), .op2_i(op2_i),
    .alu_op_i(alu_op_i), .alu_sub_i(alu_sub_i),
    .shift_left_i(shift_left_i), .shift_arith_i(shift_arith_i),
    .br_cond_i(br_cond_i), .br_off_i(br_off_i),
    .ls_enable_i(ls_enable_i), .ls_write_i(ls_write_i), .ls_unsigned_i(ls_unsigned_i),
    .ls_sel_i(ls_sel_i), .ls_wdata_i(ls_wdata_i),
    .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
    .output_valid_o(output_valid_o), .output_ready_i(output_ready_i),
    .alu_result_o(alu_result_o),
    .ls_enable_o(ls_enable_o), .ls_write_o(ls_write_o), .ls_unsigned_o(ls_unsigned_o),
    .ls_sel_o(ls_sel_o), .ls_wdata_o(ls_wdata_o),
    .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o),
    .branch_o(branch_o), .branch_target_o(branch_target_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] model_alu();
    logic [31:0] a = op1_i;
    logic [31:0] b = op2_i;
    case (alu_op_i)
      3'd0: return alu_sub_i ? a - b : a + b;
      3'd1: return a ^ b;
      3'd2: return a | b;
      3'd3: return a & b;
      3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: return (a < b) ? 32'd1 : 32'd0;
      3'd6: begin
        if (shift_left_i)  return a << b[4:0];
        if (shift_arith_i) return 32'($signed(a) >>> b[4:0]);
        return a >> b[4:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_taken();
    case (br_cond_i)
      3'd1: return op1_i == op2_i;
      3'd2: return op1_i != op2_i;
      3'd3: return $signed(op1_i) < $signed(op2_i);
      3'd4: return $signed(op1_i) >= $signed(op2_i);
      3'd5: return op1_i < op2_i;
      3'd6: return op1_i >= op2_i;
      3'd7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: check the current cycle, account for the coming edge, then advance.
  task automatic step();
    exp_t e, act;
    logic br_next;
    #1;
    n_cmp++;
    if (branch_o !== exp_br) begin
      n_bad++; $display("FAIL branch_pulse: got %b want %b @%0t", branch_o, exp_br, $time);
    end
    n_cmp++;
    if (branch_target_o !== exp_tgt) begin
      n_bad++;
      $display("FAIL branch_target: got %h want %h @%0t", branch_target_o, exp_tgt, $time);
    end
    if (!output_valid_o) begin
      n_cmp++;
      if (reg_write_o !== 1'b0) begin
        n_bad++; $display("FAIL reg_write_idle: got %b want 0 @%0t", reg_write_o, $time);
      end
    end
    if (output_valid_o && output_ready_i) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++; $display("FAIL unexpected_output: result %h with empty scoreboard", alu_result_o);
      end else begin
        e   = sbq.pop_front();
        act = '{alu_result_o, ls_enable_o, ls_write_o, ls_unsigned_o, ls_sel_o, ls_wdata_o,
                reg_write_o, reg_addr_o};
        if (act !== e) begin
          n_bad++; $display("FAIL slot_contents: got %h want %h @%0t", act, e, $time);
        end
      end
    end
    acc_flag = input_valid_i && input_ready_o;
    br_next  = 1'b0;
    if (acc_flag) begin
      sbq.push_back('{model_alu(), ls_enable_i, ls_write_i, ls_unsigned_i, ls_sel_i, ls_wdata_i,
                      reg_write_i, reg_addr_i});
      if (model_taken()) begin
        br_next = 1'b1;
        exp_tgt = pc_i + {{(32 - BW){br_off_i[BW-1]}}, br_off_i};
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
    exp_br = br_next;
  endtask

  task automatic set_in(input logic [2:0] op, input logic sub, input logic left,
                        input logic arith, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] cond, input logic [31:0] pc, input logic [BW-1:0] off);
    alu_op_i = op; alu_sub_i = sub; shift_left_i = left; shift_arith_i = arith;
    op1_i = a; op2_i = b; br_cond_i = cond; pc_i = pc; br_off_i = off;
    ls_enable_i = 1'($urandom); ls_write_i = 1'($urandom); ls_unsigned_i = 1'($urandom);
    ls_sel_i = 4'($urandom); ls_wdata_i = $urandom; reg_write_i = 1'($urandom);
    reg_addr_i = 5'($urandom);
  endtask

  task automatic issue(input logic [2:0] op, input logic sub, input logic left,
                       input logic arith, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] cond, input logic [31:0] pc, input logic [BW-1:0] off);
    logic got = 1'b0;
    set_in(op, sub, left, arith, a, b, cond, pc, off);
    input_valid_i = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      step();
      got = acc_flag;
    end
    input_valid_i = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++; $display("FAIL accept_timeout: got no accept want accept");
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [143:0] v;
    v = {output_valid_o, alu_result_o, ls_enable_o, ls_write_o, ls_unsigned_o, ls_sel_o,
         ls_wdata_o, reg_write_o, reg_addr_o, branch_o, branch_target_o};
    n_cmp++;
    if (v !== '0) begin n_bad++; $display("FAIL %s_outputs: got %h want 0", name, v); end
    n_cmp++;
    if (input_ready_o !== 1'b1) begin
      n_bad++; $display("FAIL %s_ready: got %b want 1", name, input_ready_o);
    end
  endtask

  task automatic test_reset();
    check_all_zero("reset");
  endtask

  task automatic test_alu();
    output_ready_i = 1'b1;
    issue(3'd0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 3'd0, 32'h0, '0);
    n_cmp++;
    if (output_valid_o !== 1'b1 || alu_result_o !== 32'd12) begin
      n_bad++; $display("FAIL add_5_7: got v=%b %h want v=1 0000000c", output_valid_o, alu_result_o);
    end
    issue(3'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd1, 3'd0, 32'h0, '0);
    n_cmp++;
    if (alu_result_o !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL sub_0_1: got %h want ffffffff", alu_result_o);
    end
    issue(3'd5, 1'b0, 1'b0, 1'b0, 32'd0, 32'd1, 3'd0, 32'h0, '0);
    n_cmp++;
    if (alu_result_o !== 32'd1) begin
      n_bad++; $display("FAIL sltu_0_1: got %h want 00000001", alu_result_o);
    end
    issue(3'd4, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 3'd0, 32'h0, '0);
    n_cmp++;
    if (alu_result_o !== 32'd1) begin
      n_bad++; $display("FAIL slt_min_1: got %h want 00000001", alu_result_o);
    end
    issue(3'd5, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 3'd0, 32'h0, '0);
    n_cmp++;
    if (alu_result_o !== 32'd0) begin
      n_bad++; $display("FAIL sltu_min_1: got %h want 00000000", alu_result_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] op, cond;
    output_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op   = 3'($urandom_range(0, 6));
      cond = (op == 3'd6) ? 3'd0 : 3'($urandom);
      issue(op, 1'($urandom), 1'($urandom), 1'($urandom), $urandom,
            (i % 4 == 0) ? 32'($urandom_range(0, 2)) : $urandom, cond, $urandom, BW'($urandom));
    end
    repeat (3) step();
  endtask

  task automatic test_backpressure();
    output_ready_i = 1'b0;
    issue(3'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2, 3'd0, 32'h0, '0);
    set_in(3'd1, 1'b0, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'd0, 32'h0, '0);
    input_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (input_ready_o !== 1'b0 || output_valid_o !== 1'b1 || alu_result_o !== 32'd3) begin
        n_bad++;
        $display("FAIL stall_hold: got rdy=%b v=%b %h want rdy=0 v=1 00000003",
                 input_ready_o, output_valid_o, alu_result_o);
      end
      step();
    end
    output_ready_i = 1'b1;
    step();
    input_valid_i = 1'b0;
    n_cmp++;
    if (output_valid_o !== 1'b1 || alu_result_o !== 32'hFF00_EDCB) begin
      n_bad++;
      $display("FAIL drain_and_load: got v=%b %h want v=1 ff00edcb", output_valid_o, alu_result_o);
    end
    step();
    n_cmp++;
    if (output_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL drain_only: got v=%b want 0", output_valid_o);
    end
  endtask

  task automatic test_branch();
    output_ready_i = 1'b1;
    issue(3'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, 3'd3, 32'h100, BW'(-8));
    n_cmp++;
    if (branch_o !== 1'b1 || branch_target_o !== 32'hF8) begin
      n_bad++; $display("FAIL blt_taken: got %b %h want 1 000000f8", branch_o, branch_target_o);
    end
    step();
    n_cmp++;
    if (branch_o !== 1'b0) begin
      n_bad++; $display("FAIL blt_one_cycle: got %b want 0", branch_o);
    end
    issue(3'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, 3'd5, 32'h200, BW'(16));
    n_cmp++;
    if (branch_o !== 1'b0 || branch_target_o !== 32'hF8) begin
      n_bad++; $display("FAIL bltu_not_taken: got %b %h want 0 000000f8", branch_o, branch_target_o);
    end
    issue(3'd0, 1'b0, 1'b0, 1'b0, 32'd9, 32'd9, 3'd0, 32'h300, BW'(4));
    n_cmp++;
    if (branch_o !== 1'b0) begin
      n_bad++; $display("FAIL cond_none: got %b want 0", branch_o);
    end
    issue(3'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2, 3'd7, 32'h1000, BW'(-16'sh100));
    n_cmp++;
    if (branch_o !== 1'b1 || branch_target_o !== 32'hF00) begin
      n_bad++; $display("FAIL jump_always: got %b %h want 1 00000f00", branch_o, branch_target_o);
    end
    step();
  endtask

  task automatic test_shift();
    int lat;
    output_ready_i = 1'b1;
    issue(3'd6, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd31, 3'd0, 32'h0, '0);
    lat = 1;
    while (!output_valid_o && lat < 60) begin
      n_cmp++;
      if (input_ready_o !== 1'b0) begin
        n_bad++; $display("FAIL shift_busy_ready: got %b want 0", input_ready_o);
      end
      step();
      lat++;
    end
    n_cmp++;
    if (lat != SHIFT31_LAT) begin
      n_bad++; $display("FAIL shift_latency: got %0d want %0d", lat, SHIFT31_LAT);
    end
    n_cmp++;
    if (alu_result_o !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL sra_31: got %h want ffffffff", alu_result_o);
    end
    issue(3'd6, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'hFFFF_FFE0, 3'd0, 32'h0, '0);
    issue(3'd6, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'd4, 3'd0, 32'h0, '0);
    issue(3'd6, 1'b0, 1'b0, 1'b0, 32'h8000_0001, 32'd1, 3'd0, 32'h0, '0);
    for (int i = 0; i < 40 && sbq.size() != 0; i++) step();
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++; $display("FAIL shift_drain: got %0d pending want 0", sbq.size());
    end
  endtask

  task automatic test_reset_mid();
    output_ready_i = 1'b0;
    issue(3'd2, 1'b0, 1'b0, 1'b0, 32'h00F0, 32'h0F00, 3'd7, 32'h40, BW'(8));
    output_ready_i = 1'b1;
    issue(3'd6, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'd20, 3'd0, 32'h0, '0);
    output_ready_i = 1'b0;
    repeat (3) step();
    rst_i = 1'b1;
    step();
    sbq.delete();
    exp_br  = 1'b0;
    exp_tgt = '0;
    check_all_zero("reset_mid");
    rst_i = 1'b0;
    output_ready_i = 1'b1;
    issue(3'd3, 1'b0, 1'b0, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 3'd0, 32'h0, '0);
    repeat (2) step();
  endtask

  initial begin
    rst_i = 1'b1;
    input_valid_i = 1'b0;
    output_ready_i = 1'b0;
    set_in(3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 32'd0, '0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    test_reset();
    rst_i = 1'b0;
    test_alu();
    test_back_to_back();
    test_backpressure();
    test_branch();
    test_shift();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
